// File: rtl/hazard_issue_ctrl_pkg.sv
// Shared types for the decode-stage hazard/issue sequencer.
// Optional STALL_PERF_CNT_EN adds stall/issue counters.
package hazard_pkg;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_BUSY = 2'd1,
    EX_HOLD = 2'd2
  } ex_state_t;
endpackage

// File: rtl/hazard_issue_ctrl_if.sv
// Decode/EX/MEM/WB handshake bundle of hazard_issue_ctrl.
// Counter ports exist only with STALL_PERF_CNT_EN.
interface hazard_issue_ctrl_if
  import hazard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW = AW_DEF
);
  logic          id_valid_i;
  logic [AW-1:0] A1_ID_i;
  logic [AW-1:0] A2_ID_i;
  logic [AW-1:0] A3_ID_i;
  logic          RegFile_WE_ID_i;
  logic          is_mem_ID_i;
  logic          Exe_Finished_i;
  logic          Mem_Finished_i;
  logic          RFWE_WB_i;
  logic [AW-1:0] A3_WB_i;
  logic          stall_IF_o;
  logic          enable_ID_EX_o;
  logic          bubble_o;
  logic [NREG-1:0] busy_mask_o;
  logic [1:0]    ex_state_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0]   stall_cnt_o;
  logic [31:0]   issue_cnt_o;
`endif

  modport master (
    output id_valid_i, A1_ID_i, A2_ID_i, A3_ID_i,
    output RegFile_WE_ID_i, is_mem_ID_i,
    output Exe_Finished_i, Mem_Finished_i,
    output RFWE_WB_i, A3_WB_i,
`ifdef STALL_PERF_CNT_EN
    input  stall_cnt_o, issue_cnt_o,
`endif
    input  stall_IF_o, enable_ID_EX_o, bubble_o,
    input  busy_mask_o, ex_state_o
  );

  modport slave (
    input  id_valid_i, A1_ID_i, A2_ID_i, A3_ID_i,
    input  RegFile_WE_ID_i, is_mem_ID_i,
    input  Exe_Finished_i, Mem_Finished_i,
    input  RFWE_WB_i, A3_WB_i,
`ifdef STALL_PERF_CNT_EN
    output stall_cnt_o, issue_cnt_o,
`endif
    output stall_IF_o, enable_ID_EX_o, bubble_o,
    output busy_mask_o, ex_state_o
  );
endinterface

// File: rtl/hazard_issue_ctrl_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register,
// three combinational read ports, set beats clear.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_i,
  input  logic [AW-1:0]   set_a_i,
  input  logic            clr_i,
  input  logic [AW-1:0]   clr_a_i,
  input  logic [AW-1:0]   rd1_a_i,
  input  logic [AW-1:0]   rd2_a_i,
  input  logic [AW-1:0]   rd3_a_i,
  output logic            rd1_o,
  output logic            rd2_o,
  output logic            rd3_o,
  output logic [NREG-1:0] busy_o
);
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_a_i] = 1'b0;
    if (set_i) busy_d[set_a_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rd1_o  = busy_q[rd1_a_i];
  assign rd2_o  = busy_q[rd2_a_i];
  assign rd3_o  = busy_q[rd3_a_i];
  assign busy_o = busy_q;
endmodule

// File: rtl/hazard_issue_ctrl.sv
// Decode-stage issue sequencer: scoreboard + EX/MEM occupancy.
// Define STALL_PERF_CNT_EN for stall/issue counters.
module hazard_issue_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW = AW_DEF
) (
  input logic CLK,
  input logic RST,
  hazard_issue_ctrl_if.slave bus
);
  ex_state_t ex_state_q, ex_state_d;
  logic      ex_mem_q, ex_mem_d;
  logic      mem_busy_q, mem_busy_d;
  logic      mem_free;
  logic      ex_free;
  logic      hz1, hz2, hz3;
  logic      hazard;
  logic      issue;
  logic      stall_raw;

  reg_scoreboard #(
    .NREG(NREG),
    .AW  (AW)
  ) u_sb (
    .clk    (CLK),
    .rst    (RST),
    .set_i  (issue & bus.RegFile_WE_ID_i),
    .set_a_i(bus.A3_ID_i),
    .clr_i  (bus.RFWE_WB_i),
    .clr_a_i(bus.A3_WB_i),
    .rd1_a_i(bus.A1_ID_i),
    .rd2_a_i(bus.A2_ID_i),
    .rd3_a_i(bus.A3_ID_i),
    .rd1_o  (hz1),
    .rd2_o  (hz2),
    .rd3_o  (hz3),
    .busy_o (bus.busy_mask_o)
  );

  always_comb begin
    mem_free = ~mem_busy_q | bus.Mem_Finished_i;
    ex_free  = 1'b0;
    unique case (ex_state_q)
      EX_IDLE: ex_free = 1'b1;
      EX_BUSY: ex_free = bus.Exe_Finished_i
                       & (~ex_mem_q | mem_free);
      EX_HOLD: ex_free = mem_free;
      default: ex_free = 1'b0;
    endcase
  end

  assign hazard = hz1 | hz2 | (bus.RegFile_WE_ID_i & hz3);
  assign issue  = bus.id_valid_i & ~hazard & ex_free & ~RST;

  // Issue takes priority over whatever EX was about to retire to.
  always_comb begin
    ex_state_d = ex_state_q;
    ex_mem_d   = ex_mem_q;
    mem_busy_d = mem_busy_q & ~bus.Mem_Finished_i;
    unique case (ex_state_q)
      EX_BUSY: begin
        if (bus.Exe_Finished_i) begin
          if (!ex_mem_q) begin
            ex_state_d = EX_IDLE;
          end else if (mem_free) begin
            ex_state_d = EX_IDLE;
            mem_busy_d = 1'b1;
          end else begin
            ex_state_d = EX_HOLD;
          end
        end
      end
      EX_HOLD: begin
        if (mem_free) begin
          ex_state_d = EX_IDLE;
          mem_busy_d = 1'b1;
        end
      end
      EX_IDLE: ex_state_d = EX_IDLE;
      default: ex_state_d = EX_IDLE;
    endcase
    if (issue) begin
      ex_state_d = EX_BUSY;
      ex_mem_d   = bus.is_mem_ID_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_state_q <= EX_IDLE;
      ex_mem_q   <= 1'b0;
      mem_busy_q <= 1'b0;
    end else begin
      ex_state_q <= ex_state_d;
      ex_mem_q   <= ex_mem_d;
      mem_busy_q <= mem_busy_d;
    end
  end

  assign stall_raw = bus.id_valid_i & ~issue;

  always_comb begin
    bus.stall_IF_o     = stall_raw;
    bus.enable_ID_EX_o = ex_free;
    bus.bubble_o       = ex_free & ~issue;
    if (RST) begin
      bus.stall_IF_o     = 1'b1;
      bus.enable_ID_EX_o = 1'b0;
      bus.bubble_o       = 1'b0;
    end
  end

  assign bus.ex_state_o = ex_state_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_raw & ~RST};
    issue_cnt_d = issue_cnt_q + {31'd0, issue};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.issue_cnt_o = issue_cnt_q;
`endif
endmodule

// File: doc/hazard_issue_ctrl.md
Name: hazard_issue_ctrl

Overview:
- Single-issue pipeline sequencer placed at the decode stage of the vector ASIP.
- Keeps a per-register scoreboard of pending writes, one bit for each of the 32 unified scalar/vector registers.
- Tracks occupancy of the multi-cycle EX and MEM stages using the Exe_Finished/Mem_Finished handshakes.
- Drives the IF/ID stall and the Pipe_ID_EX enable/bubble, so an instruction issues only when its operands are clean and EX can accept it.

Parameters:
- NREG, 32, number of architectural registers (scoreboard width).
- AW, 5, register address width; must equal clog2(NREG).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- id_valid_i  in  1  decode holds a valid instruction.
- A1_ID_i  in  AW  source register 1.
- A2_ID_i  in  AW  source register 2.
- A3_ID_i  in  AW  destination register.
- RegFile_WE_ID_i  in  1  instruction writes A3.
- is_mem_ID_i  in  1  instruction uses the MEM stage (load/store).
- Exe_Finished_i  in  1  EX operation completes this cycle.
- Mem_Finished_i  in  1  MEM operation completes this cycle.
- RFWE_WB_i  in  1  writeback writes the register file this cycle.
- A3_WB_i  in  AW  writeback destination.
- stall_IF_o  out  1  hold PC and Pipe_IF_ID.
- enable_ID_EX_o  out  1  load Pipe_ID_EX this cycle.
- bubble_o  out  1  Pipe_ID_EX loads a NOP (all write enables 0).
- busy_mask_o  out  NREG  current scoreboard.
- ex_state_o  out  2  EX FSM state.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - busy=0, ex_state=EX_IDLE, mem_busy=0.
  - While RST is high, outputs are forced: stall_IF_o=1, enable_ID_EX_o=0, bubble_o=0.
  - Reset mid-operation discards all pending state, with no drain.
- EX FSM:
  - EX_IDLE(0): EX holds nothing.
  - EX_BUSY(1): EX holds an instruction; waits for Exe_Finished_i.
  - EX_HOLD(2): EX finished a mem-op but MEM is occupied.
  - Transitions:
    - EX_BUSY + Exe_Finished_i & !ex_mem_q -> EX_IDLE.
    - EX_BUSY + Exe_Finished_i & ex_mem_q & mem_free -> EX_IDLE, with mem_busy set.
    - EX_BUSY + Exe_Finished_i & ex_mem_q & !mem_free -> EX_HOLD.
    - EX_HOLD + mem_free -> EX_IDLE, with mem_busy set.
    - Any state + issue -> EX_BUSY. Issue overrides the IDLE target; ex_mem_q <= is_mem_ID_i.
  - Exe_Finished_i in EX_IDLE/EX_HOLD is ignored.
- mem_free = !mem_busy | Mem_Finished_i. Mem_Finished_i clears mem_busy unless it is re-set in the same cycle.
- ex_free (combinational): true when
  - ex_state=EX_IDLE, or
  - EX_BUSY & Exe_Finished_i & (!ex_mem_q | mem_free), or
  - EX_HOLD & mem_free.
- hazard = busy[A1] | busy[A2] | (RegFile_WE_ID_i & busy[A3]). RAW and WAW are both checked.
- issue = id_valid_i & !hazard & ex_free & !RST.
- Combinational outputs:
  - stall_IF_o = id_valid_i & !issue.
  - enable_ID_EX_o = ex_free.
  - bubble_o = ex_free & !issue.
- Issue latency: 0 cycles, so a clean instruction issues in the same cycle it is decoded.
- Scoreboard updates at the CLK edge:
  - Set busy[A3_ID_i] on issue & RegFile_WE_ID_i.
  - Clear busy[A3_WB_i] on RFWE_WB_i.
  - Set and clear of the same register in the same cycle: set wins.
- The hazard check uses the registered busy only; there is no same-cycle writeback bypass. A consumer therefore issues one cycle after the WB clear.
- Register 0 is tracked like any other register.
- A1=A2=A3 on the same register produces a single hazard term; there is no special case.

Optional Feature:
- STALL_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [31:0], counting cycles with stall_IF_o=1 & !RST.
  - Adds output issue_cnt_o [31:0], counting issues.
  - Both reset to 0, wrap modulo 2^32, and saturate never.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - typedef enum logic [1:0] ex_state_t {EX_IDLE, EX_BUSY, EX_HOLD}.
  - localparam NREG_DEF=32, AW_DEF=5.
- One sub-module, reg_scoreboard:
  - Holds the NREG busy bits and their set/clear priority.
  - Two combinational read ports for A1/A2 plus a third for A3.
  - FSM and issue logic stay in the top.

Test Plan:
1. RST for 2 cycles, then id_valid_i=1, A1=3, A2=4, A3=5, WE=1, Exe_Finished_i=1 -> issue in the same cycle: stall_IF_o=0, bubble_o=0, busy_mask_o=0x20 on the next cycle.
2. Back-to-back RAW:
   - Stimulus: issue writes r5; the next instruction reads A1=5.
   - Stalls while busy[5]=1.
   - RFWE_WB_i=1, A3_WB_i=5 at cycle n -> consumer issues at cycle n+1, not n.
3. Multi-cycle EX: issue with Exe_Finished_i held 0 for 4 cycles -> stall_IF_o=1 and enable_ID_EX_o=0 for 4 cycles; issue on the cycle Exe_Finished_i=1.
4. Mem contention:
   - Stimulus: mem-op A in MEM (Mem_Finished_i=0); mem-op B completes EX.
   - ex_state goes to EX_HOLD(2).
   - Mem_Finished_i=1 -> EX_IDLE, mem_busy stays 1, next instruction issues.
5. Same-cycle set/clear of r7 (issue A3=7, WB A3_WB=7) -> busy[7]=1 afterwards.
6. RST asserted while in EX_BUSY with busy=0x80 -> next cycle: busy=0, ex_state=0, stall_IF_o=1 during reset. With STALL_PERF_CNT_EN defined, stall_cnt_o=0.
